// File: rtl/uart_bytes_tx.sv
// Multi-byte 8N1 UART transmitter: sends BYTES frames back-to-back, MSB byte first, LSB bit first.
// Line goes low the cycle after accept; start requests are ignored while busy or during the done-pulse cycle.
module uart_bytes_tx #(
    parameter int BYTES   = 5,
    parameter int BPS     = 230400,
    parameter int CLK_FRE = 50_000_000
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [BYTES*8-1:0] uart_bytes_data,
    input  logic               uart_bytes_en,
    output logic               uart_bytes_busy,
    output logic               uart_bytes_done,
    output logic               uart_txd
);

    localparam int BAUD_CNT = CLK_FRE / BPS;
    localparam int BAUD_W   = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;
    localparam int BYTE_W   = $clog2(BYTES + 1);
    localparam int DATA_W   = BYTES * 8;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_CNT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t              r_state;
    logic [BAUD_W-1:0]   r_baud_cnt;
    logic [2:0]          r_bit_cnt;
    logic [BYTE_W-1:0]   r_byte_cnt;
    logic [DATA_W-1:0]   r_shift;
    logic                r_txd;
    logic                r_busy;
    logic                r_done;

    state_t              w_state_nxt;
    logic [BAUD_W-1:0]   w_baud_nxt;
    logic [2:0]          w_bit_nxt;
    logic [BYTE_W-1:0]   w_byte_nxt;
    logic [DATA_W-1:0]   w_shift_nxt;
    logic [7:0]          w_cur_byte;
    logic                w_txd_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic                w_baud_wrap;
    logic                w_accept;

    assign w_baud_wrap = (r_baud_cnt == BAUD_LAST);
    // The done-pulse cycle is not an accept slot, so a held en restarts one cycle later.
    assign w_accept    = (r_state == S_IDLE) && uart_bytes_en && !r_done;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_shift    <= '0;
            r_txd      <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_byte_cnt <= w_byte_nxt;
            r_shift    <= w_shift_nxt;
            r_txd      <= w_txd_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_byte_nxt  = r_byte_cnt;
        w_shift_nxt = r_shift;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_START;
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_byte_nxt  = '0;
                    w_shift_nxt = uart_bytes_data;
                end
            end
            S_START: begin
                if (w_baud_wrap) begin
                    w_state_nxt = S_DATA;
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                end else begin
                    w_baud_nxt  = r_baud_cnt + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (w_baud_wrap) begin
                    w_baud_nxt = '0;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = S_STOP;
                        w_bit_nxt   = '0;
                    end else begin
                        w_bit_nxt   = r_bit_cnt + 3'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud_cnt + BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (w_baud_wrap) begin
                    w_baud_nxt = '0;
                    if (r_byte_cnt == BYTE_LAST) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_START;
                        w_byte_nxt  = r_byte_cnt + BYTE_W'(1);
                        w_shift_nxt = r_shift << 8;
                    end
                end else begin
                    w_baud_nxt = r_baud_cnt + BAUD_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are computed from next-state values so the registered line tracks the state exactly.
    always_comb begin
        w_cur_byte = w_shift_nxt[DATA_W-1 -: 8];
        w_txd_nxt  = 1'b1;
        case (w_state_nxt)
            S_START: w_txd_nxt = 1'b0;
            S_DATA:  w_txd_nxt = w_cur_byte[w_bit_nxt];
            default: w_txd_nxt = 1'b1;
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_done_nxt = (r_state == S_STOP) && (w_state_nxt == S_IDLE);
    end

    assign uart_txd        = r_txd;
    assign uart_bytes_busy = r_busy;
    assign uart_bytes_done = r_done;

endmodule

// File: tb/tb_uart_bytes_tx.sv
// Directed bench for uart_bytes_tx at default parameters; a line decoder rebuilds bytes from uart_txd.
`timescale 1ns/1ps
module tb_uart_bytes_tx;

    localparam int BAUD  = 217;
    localparam int FRAME = 50 * BAUD;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [39:0] uart_bytes_data = '0;
    logic        uart_bytes_en = 1'b0;
    logic        uart_bytes_busy;
    logic        uart_bytes_done;
    logic        uart_txd;

    int          n_cmp = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    int          frm_err = 0;
    logic [7:0]  rx_q[$];

    int          waited;
    int          hi;
    int          base;
    logic [9:0]  bits;
    logic [39:0] words[3];

    always #10 sys_clk = ~sys_clk;

    uart_bytes_tx dut (
        .sys_clk         (sys_clk),
        .sys_rst_n       (sys_rst_n),
        .uart_bytes_data (uart_bytes_data),
        .uart_bytes_en   (uart_bytes_en),
        .uart_bytes_busy (uart_bytes_busy),
        .uart_bytes_done (uart_bytes_done),
        .uart_txd        (uart_txd)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input int budget, output int cnt);
        cnt = 0;
        while (uart_bytes_done !== 1'b1 && cnt < budget) begin
            @(negedge sys_clk);
            cnt++;
        end
    endtask

    task automatic check_word(input string tag, input logic [39:0] exp);
        logic [39:0] w;
        w = '0;
        if (rx_q.size() < 5) begin
            check_eq({tag, "_nbytes"}, 64'(rx_q.size()), 64'd5);
        end else begin
            for (int k = 0; k < 5; k++) w = {w[31:0], rx_q.pop_front()};
            check_eq(tag, w, exp);
        end
    endtask

    always @(negedge sys_clk) begin
        if (uart_bytes_done === 1'b1) done_cnt++;
    end

    // Line decoder: samples each bit at its middle.
    initial begin : line_mon
        logic [7:0] b;
        b = '0;
        forever begin
            @(negedge sys_clk);
            if (sys_rst_n === 1'b1 && uart_txd === 1'b0) begin
                repeat (BAUD / 2) @(negedge sys_clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BAUD) @(negedge sys_clk);
                    b[i] = uart_txd;
                end
                repeat (BAUD) @(negedge sys_clk);
                if (uart_txd !== 1'b1) frm_err++;
                rx_q.push_back(b);
            end
        end
    end

    initial begin : watchdog
        #(2_500_000);
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "timeout");
    end

    initial begin : stim
        // T1 reset
        repeat (3) @(negedge sys_clk);
        check_eq("t1_rst_txd", uart_txd, 1'b1);
        check_eq("t1_rst_busy", uart_bytes_busy, 1'b0);
        check_eq("t1_rst_done", uart_bytes_done, 1'b0);
        sys_rst_n = 1'b1;
        hi = 0;
        repeat (100) begin
            @(negedge sys_clk);
            if (uart_txd === 1'b1) hi++;
        end
        check_eq("t1_idle_high", hi, 100);
        check_eq("t1_idle_busy", uart_bytes_busy, 1'b0);

        // T2 single transfer: first frame of 0x55 is 0,1,0,1,0,1,0,1,0,1
        uart_bytes_data = 40'h55A300FF81;
        uart_bytes_en   = 1'b1;
        @(negedge sys_clk);
        uart_bytes_en   = 1'b0;
        check_eq("t2_start_low", uart_txd, 1'b0);
        check_eq("t2_busy", uart_bytes_busy, 1'b1);
        bits = 10'b1010101010;
        for (int i = 0; i < 10; i++) begin
            check_eq($sformatf("t2_bit%0d_first", i), uart_txd, bits[i]);
            repeat (BAUD - 1) @(negedge sys_clk);
            check_eq($sformatf("t2_bit%0d_last", i), uart_txd, bits[i]);
            @(negedge sys_clk);
        end
        wait_done(FRAME, waited);
        check_eq("t2_done_seen", uart_bytes_done, 1'b1);
        check_eq("t2_latency", 64'(10 * BAUD + waited), 64'(FRAME));
        check_eq("t2_busy_at_done", uart_bytes_busy, 1'b0);
        @(negedge sys_clk);
        check_eq("t2_done_pulse", uart_bytes_done, 1'b0);
        check_word("t2_word", 40'h55A300FF81);

        // T4 en while busy is ignored
        uart_bytes_data = 40'h1122334455;
        uart_bytes_en   = 1'b1;
        @(negedge sys_clk);
        uart_bytes_en   = 1'b0;
        check_eq("t4_busy", uart_bytes_busy, 1'b1);
        base = done_cnt;
        repeat (25 * BAUD) @(negedge sys_clk);
        uart_bytes_data = '1;
        uart_bytes_en   = 1'b1;
        @(negedge sys_clk);
        uart_bytes_en   = 1'b0;
        check_eq("t4_busy_mid", uart_bytes_busy, 1'b1);
        wait_done(FRAME, waited);
        check_eq("t4_done_seen", uart_bytes_done, 1'b1);
        repeat (600) @(negedge sys_clk);
        check_eq("t4_done_count", 64'(done_cnt - base), 64'd1);
        check_eq("t4_idle_txd", uart_txd, 1'b1);
        check_eq("t4_idle_busy", uart_bytes_busy, 1'b0);
        check_word("t4_word", 40'h1122334455);
        check_eq("t4_no_extra", 64'(rx_q.size()), 64'd0);

        // T3/T5 back-to-back random words with en held high
        for (int k = 0; k < 3; k++) words[k] = {8'($urandom), 32'($urandom)};
        uart_bytes_data = words[0];
        uart_bytes_en   = 1'b1;
        @(negedge sys_clk);
        check_eq("t5_acc_txd", uart_txd, 1'b0);
        check_eq("t5_acc_busy", uart_bytes_busy, 1'b1);
        for (int k = 0; k < 3; k++) begin
            uart_bytes_data = (k < 2) ? words[k + 1] : ~words[2];
            wait_done(FRAME, waited);
            check_eq($sformatf("t5_done%0d", k), uart_bytes_done, 1'b1);
            check_eq($sformatf("t5_done_txd%0d", k), uart_txd, 1'b1);
            if (k < 2) begin
                @(negedge sys_clk);
                check_eq($sformatf("t5_gap_txd%0d", k), uart_txd, 1'b1);
                check_eq($sformatf("t5_gap_busy%0d", k), uart_bytes_busy, 1'b0);
                @(negedge sys_clk);
                check_eq($sformatf("t5_fall%0d", k), uart_txd, 1'b0);
                check_eq($sformatf("t5_rebusy%0d", k), uart_bytes_busy, 1'b1);
            end else begin
                uart_bytes_en = 1'b0;
            end
        end
        repeat (50) @(negedge sys_clk);
        check_eq("t5_final_busy", uart_bytes_busy, 1'b0);
        for (int k = 0; k < 3; k++) check_word($sformatf("t3_word%0d", k), words[k]);

        // T6 reset during data of the third byte
        uart_bytes_data = 40'hDEADBEEF01;
        uart_bytes_en   = 1'b1;
        @(negedge sys_clk);
        uart_bytes_en   = 1'b0;
        repeat (24 * BAUD + 50) @(negedge sys_clk);
        check_eq("t6_busy_before", uart_bytes_busy, 1'b1);
        base = done_cnt;
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        check_eq("t6_rst_txd", uart_txd, 1'b1);
        check_eq("t6_rst_busy", uart_bytes_busy, 1'b0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (2400) @(negedge sys_clk);
        check_eq("t6_no_done", 64'(done_cnt - base), 64'd0);
        check_eq("t6_idle_txd", uart_txd, 1'b1);
        rx_q.delete();
        uart_bytes_data = 40'h0123456789;
        uart_bytes_en   = 1'b1;
        @(negedge sys_clk);
        uart_bytes_en   = 1'b0;
        wait_done(FRAME + 10, waited);
        check_eq("t6_done_seen", uart_bytes_done, 1'b1);
        check_word("t6_word", 40'h0123456789);

        check_eq("frame_errs", 64'(frm_err), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
